load_store_ctrl: RTL and testbench
==================================

# load_store_ctrl

Issuing side of the 8 x 16-bit data memory: owns the 8-entry register file whose contents feed the memory's `Reg_0`..`Reg_7` inputs, and accepts one LOAD/STORE instruction at a time from the host. For each instruction it drives the memory's `instruction` and `run` pins, and on a LOAD writes the returned `out` word back into register Rx. It sits between the instruction source and the memory and gives the host a ready/done handshake, so the host never has to track the memory's one-cycle read latency.

## Interface
- No parameters; data width 16, register count 8, instruction format fixed.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only while `ready`=1.
- `instruction` in 16: [15:13] Rx, [12:10] Ry, [2] format (0 = LOAD, 1 = STORE); other bits are don't-care but are passed through unchanged.
- `host_we` in 1: host write into the register file; honoured only while `ready`=1.
- `host_sel` in 3: register index for `host_we`.
- `host_wdata` in 16: data for `host_we`.
- `mem_out` in 16: memory `out` port.
- `mem_instruction` out 16: to memory `instruction`; the latched copy of `instruction`.
- `mem_run` out 1: to memory `run`.
- `Reg_0`..`Reg_7` out 16 each: register-file contents; wired to the memory's `Reg_0`..`Reg_7` and visible for debug.
- `ready` out 1: high in IDLE.
- `done` out 1: one-cycle completion pulse.
- `op_count` out 8: count of completed instructions; wraps 255 -> 0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE** (`ready`=1):
  - On `start`=1, latch `instruction` into `mem_instruction` and go to ISSUE.
  - If `host_we`=1 in the same cycle, the host write happens on that same edge, so the new value is what a following STORE uses.
- **ISSUE:**
  - `mem_run`=1 for exactly this one cycle.
  - The memory acts on the edge that ends ISSUE: for a STORE it writes mem[Ry] <= Reg_Rx; for a LOAD it registers mem[Ry] onto `out`.
  - Next state: WAIT for a LOAD, DONE for a STORE.
- **WAIT** (LOAD only): `mem_out` is valid; on the edge that ends WAIT, reg[Rx] <= `mem_out`. Next state: DONE.
- **DONE:** `done`=1 for one cycle; `op_count` increments on the edge that ends DONE. Next state: IDLE.
- Outside IDLE, `start` and `host_we` are ignored. Nothing is queued, and the register file changes only through a LOAD writeback.
- Rx = Ry is legal: a LOAD overwrites Rx, a STORE writes reg[Rx] to mem[Rx].
- `mem_instruction` holds its value after the op completes; the memory ignores it while `mem_run`=0.
- The memory has no reset, so its contents are undefined until stored. A LOAD from an unwritten address returns X; that is not a controller error.

## Timing
- Reset values:
  - state IDLE, `ready`=1, `done`=0, `mem_run`=0;
  - `mem_instruction`=0x0000, all `Reg_n`=0x0000, `op_count`=0.
- `start` accepted on edge T:
  - ISSUE in cycle T+1 (`mem_run`=1).
  - STORE: `done` in cycle T+2, `ready` again in T+3.
  - LOAD: WAIT in T+2, Rx updated on the edge ending T+2, `done` in T+3, `ready` in T+4.
- Throughput: one STORE per 3 cycles, one LOAD per 4 cycles, when `start` is held high.
- `reset` mid-operation:
  - Next state is IDLE, with every output and register at its reset value.
  - `mem_run` is low in the cycle after the reset edge.
  - A LOAD in WAIT does not write back. A memory write already committed at the ISSUE edge is not undone.
- Reset has priority over `start` and `host_we` in the same cycle.

## Test plan
- **Reset:** assert `reset` 2 cycles -> `ready`=1, `done`=0, `mem_run`=0, `Reg_0`..`Reg_7`=0x0000, `op_count`=0.
- **STORE then LOAD:**
  - Stimulus: host write R3=0xBEEF; STORE 0x7404 (Rx=3, Ry=5); then LOAD 0x3400 (Rx=1, Ry=5), with the real memory model attached.
  - Response: `mem_run` high exactly one cycle per op; STORE `done` at T+2; LOAD `done` at T+3; `Reg_1`=0xBEEF; `op_count`=2.
- **Busy rejection:** pulse `start` (LOAD 0x3400) and `host_we` (R1=0x1234) during ISSUE/WAIT of a prior op -> no second `mem_run`, R1 ends at the loaded value, not 0x1234.
- **Same-cycle write and start:** in IDLE, `host_we` R2=0x00A5 with `start` STORE 0x4804 (Rx=2, Ry=2) in the same cycle; then LOAD 0x0800 (Rx=0, Ry=2) -> `Reg_0`=0x00A5.
- **Reset mid-LOAD:** assert `reset` in the WAIT cycle -> Rx is unchanged (0x0000 after reset), no `done` pulse, `ready`=1 on the next cycle.
- **Counter wrap:** run 256 back-to-back STOREs with `start` held -> `op_count` reads 0 after the 256th `done`, and `ready` is high once every 3 cycles.

Source files
------------

// File: rtl/load_store_ctrl.sv
// rtl/load_store_ctrl.sv - LOAD/STORE issue controller and register file for the 8 x 16-bit data memory
//
// Accepts one LOAD/STORE instruction at a time from the host and drives the
// memory's instruction/run pins. It owns the 8-entry register file that feeds
// the memory's Reg_0..Reg_7 inputs, and on a LOAD it writes the returned word
// back into Rx. The host sees a ready/done handshake, so it never has to track
// the memory's one-cycle read latency.
//
// Instruction format: [15:13] Rx, [12:10] Ry, [2] 0 = LOAD / 1 = STORE.
// All other bits are passed to the memory unchanged.
//
// Ports
//   clk             in   1  rising-edge clock
//   reset           in   1  synchronous, active-high
//   start           in   1  instruction request, sampled only while ready
//   instruction     in  16  instruction word, latched on an accepted start
//   host_we         in   1  host register-file write, honoured only while ready
//   host_sel        in   3  register index for host_we
//   host_wdata      in  16  data for host_we
//   mem_out         in  16  memory read data (valid in the WAIT cycle)
//   mem_instruction out 16  latched instruction, drives the memory
//   mem_run         out  1  one-cycle memory strobe (ISSUE state)
//   Reg_0..Reg_7    out 16  register-file contents
//   ready           out  1  idle, able to accept start / host_we
//   done            out  1  one-cycle completion pulse
//   op_count        out  8  completed instructions, wraps 255 -> 0

module load_store_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] instruction,
    input  logic        host_we,
    input  logic [2:0]  host_sel,
    input  logic [15:0] host_wdata,
    input  logic [15:0] mem_out,
    output logic [15:0] mem_instruction,
    output logic        mem_run,
    output logic [15:0] Reg_0,
    output logic [15:0] Reg_1,
    output logic [15:0] Reg_2,
    output logic [15:0] Reg_3,
    output logic [15:0] Reg_4,
    output logic [15:0] Reg_5,
    output logic [15:0] Reg_6,
    output logic [15:0] Reg_7,
    output logic        ready,
    output logic        done,
    output logic [7:0]  op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] regs [8];

    // Fields of the instruction currently in flight.
    logic [2:0]  cur_rx;
    logic        cur_is_store;

    assign cur_rx       = mem_instruction[15:13];
    assign cur_is_store = mem_instruction[2];

    // Host side-effects are only honoured in IDLE; everything else is dropped.
    logic        accept_start;
    logic        accept_host_we;

    assign accept_start   = (state == S_IDLE) && start;
    assign accept_host_we = (state == S_IDLE) && host_we;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        mem_run   = 1'b0;

        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The memory acts on the edge that ends this cycle: a STORE is
                // complete then, a LOAD needs one more cycle for mem_out.
                mem_run   = 1'b1;
                state_nxt = cur_is_store ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction latch: held after completion; the memory ignores it
    // while mem_run is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_instruction <= 16'h0000;
        end else if (accept_start) begin
            mem_instruction <= instruction;
        end
    end

    // ------------------------------------------------------------------
    // Register file. The host write and an accepted start may share an edge;
    // the write lands on that edge, so the STORE that follows reads it. The
    // LOAD writeback can never collide with a host write because the two
    // happen in different states. Reset in WAIT drops the writeback.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'h0000;
            end
        end else if (accept_host_we) begin
            regs[host_sel] <= host_wdata;
        end else if (state == S_WAIT) begin
            regs[cur_rx] <= mem_out;
        end
    end

    assign Reg_0 = regs[0];
    assign Reg_1 = regs[1];
    assign Reg_2 = regs[2];
    assign Reg_3 = regs[3];
    assign Reg_4 = regs[4];
    assign Reg_5 = regs[5];
    assign Reg_6 = regs[6];
    assign Reg_7 = regs[7];

    // ------------------------------------------------------------------
    // Completion counter, bumped on the edge that ends DONE; wraps naturally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= 8'h00;
        end else if (state == S_DONE) begin
            op_count <= op_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// tb/tb_load_store_ctrl.sv - scoreboard bench for load_store_ctrl with attached memory model
module tb_load_store_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] instruction;
    logic        host_we;
    logic [2:0]  host_sel;
    logic [15:0] host_wdata;
    logic [15:0] mem_out;
    logic [15:0] mem_instruction;
    logic        mem_run;
    logic [15:0] Reg_0, Reg_1, Reg_2, Reg_3, Reg_4, Reg_5, Reg_6, Reg_7;
    logic        ready;
    logic        done;
    logic [7:0]  op_count;

    always #5 clk = ~clk;

    load_store_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .instruction     (instruction),
        .host_we         (host_we),
        .host_sel        (host_sel),
        .host_wdata      (host_wdata),
        .mem_out         (mem_out),
        .mem_instruction (mem_instruction),
        .mem_run         (mem_run),
        .Reg_0           (Reg_0),
        .Reg_1           (Reg_1),
        .Reg_2           (Reg_2),
        .Reg_3           (Reg_3),
        .Reg_4           (Reg_4),
        .Reg_5           (Reg_5),
        .Reg_6           (Reg_6),
        .Reg_7           (Reg_7),
        .ready           (ready),
        .done            (done),
        .op_count        (op_count)
    );

    function automatic logic [15:0] dut_reg(input logic [2:0] i);
        case (i)
            3'd0: return Reg_0;
            3'd1: return Reg_1;
            3'd2: return Reg_2;
            3'd3: return Reg_3;
            3'd4: return Reg_4;
            3'd5: return Reg_5;
            3'd6: return Reg_6;
            default: return Reg_7;
        endcase
    endfunction

    // Data memory: no reset, acts on run at the rising edge.
    logic [15:0] mem_arr [8];
    always @(posedge clk) begin
        if (mem_run) begin
            if (mem_instruction[2])
                mem_arr[mem_instruction[12:10]] <= dut_reg(mem_instruction[15:13]);
            else
                mem_out <= mem_arr[mem_instruction[12:10]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: architectural registers/memory, op counter and the
    // earliest edge at which the controller can take a new start.
    typedef struct {
        int          cyc;
        logic [7:0]  cnt;
        logic [2:0]  rx;
        logic [15:0] val;
        logic [15:0] ins;
    } exp_t;

    exp_t        done_q[$];
    int          run_q[$];
    logic [15:0] m_reg [8];
    logic [15:0] m_mem [8];
    int          m_count;
    int          next_free;

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = done_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("op_count_at_done", {24'd0, op_count}, {24'd0, e.cnt});
                    chk("rx_value_at_done", {16'd0, dut_reg(e.rx)}, {16'd0, e.val});
                    chk("mem_instruction", {16'd0, mem_instruction}, {16'd0, e.ins});
                end
            end
            if (mem_run) begin
                if (run_q.size() == 0) begin
                    chk("unexpected_mem_run", 32'd1, 32'd0);
                end else begin
                    int rc;
                    rc = run_q.pop_front();
                    chk("mem_run_cycle", cyc, rc);
                end
            end
        end
    end

    task automatic wait_free();
        @(negedge clk);
        while (cyc + 1 < next_free) @(negedge clk);
    endtask

    task automatic wait_idle();
        @(negedge clk);
        while (cyc < next_free - 1) @(negedge clk);
    endtask

    task automatic host_write(input logic [2:0] sel, input logic [15:0] wd);
        wait_free();
        host_we = 1'b1; host_sel = sel; host_wdata = wd;
        m_reg[sel] = wd;
        @(posedge clk);
        #1 host_we = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins, input bit we, input logic [2:0] sel,
                         input logic [15:0] wd, output int e);
        logic [2:0] rx, ry;
        exp_t       x;
        wait_free();
        e  = cyc + 1;
        rx = ins[15:13];
        ry = ins[12:10];
        if (we) m_reg[sel] = wd;
        x.rx  = rx;
        x.ins = ins;
        x.cnt = m_count[7:0];
        if (ins[2]) begin
            m_mem[ry] = m_reg[rx];
            x.cyc = e + 1;
            next_free = e + 3;
        end else begin
            m_reg[rx] = m_mem[ry];
            x.cyc = e + 2;
            next_free = e + 4;
        end
        x.val = m_reg[rx];
        done_q.push_back(x);
        run_q.push_back(e);
        m_count = (m_count + 1) % 256;
        start = 1'b1; instruction = ins;
        host_we = we; host_sel = sel; host_wdata = wd;
        @(posedge clk);
        #1 start = 1'b0; host_we = 1'b0;
    endtask

    // Raise reset now (caller positions it), hold n cycles, check reset state.
    task automatic do_reset(input int n);
        reset = 1'b1;
        done_q.delete();
        run_q.delete();
        repeat (n) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mem_run", {31'd0, mem_run}, 32'd0);
        chk("rst_op_count", {24'd0, op_count}, 32'd0);
        chk("rst_mem_instruction", {16'd0, mem_instruction}, 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_reg%0d", i), {16'd0, dut_reg(3'(i))}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_count   = 0;
        next_free = cyc + 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e;
        int          mism;
        int          e0;
        logic [15:0] ins;
        exp_t        x;

        reset = 1'b1; start = 1'b0; instruction = 16'h0; host_we = 1'b0;
        host_sel = 3'd0; host_wdata = 16'h0;
        m_count = 0; next_free = 0;
        @(negedge clk);
        do_reset(2);

        // STORE then LOAD
        host_write(3'd3, 16'hBEEF);
        issue(16'h7404, 1'b0, 3'd0, 16'h0, e);
        issue(16'h3400, 1'b0, 3'd0, 16'h0, e);
        wait_idle();
        chk("store_load_reg1", {16'd0, Reg_1}, 32'h0000BEEF);
        chk("store_load_op_count", {24'd0, op_count}, 32'd2);

        // Busy rejection: start/host_we pulsed through ISSUE, WAIT and DONE
        host_write(3'd1, 16'h0000);
        issue(16'h3400, 1'b0, 3'd0, 16'h0, e);
        start = 1'b1; instruction = 16'h3400;
        host_we = 1'b1; host_sel = 3'd1; host_wdata = 16'h1234;
        while (cyc < e + 2) @(negedge clk);
        start = 1'b0; host_we = 1'b0;
        wait_idle();
        chk("busy_reg1", {16'd0, Reg_1}, 32'h0000BEEF);

        // Same-cycle host write and start
        issue(16'h4804, 1'b1, 3'd2, 16'h00A5, e);
        issue(16'h0800, 1'b0, 3'd0, 16'h0, e);
        wait_idle();
        chk("same_cycle_reg0", {16'd0, Reg_0}, 32'h000000A5);

        // Randomized traffic: fill memory first so every LOAD is defined
        for (int i = 0; i < 8; i++) begin
            host_write(3'(i), 16'($urandom));
            issue({3'(i), 3'(i), 7'($urandom), 1'b1, 2'($urandom)}, 1'b0, 3'd0, 16'h0, e);
        end
        for (int i = 0; i < 60; i++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) == 0) host_write(3'($urandom), 16'($urandom));
            issue(ins, 1'($urandom), 3'($urandom), 16'($urandom), e);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        wait_idle();
        for (int i = 0; i < 8; i++) chk($sformatf("rand_reg%0d", i), {16'd0, dut_reg(3'(i))}, {16'd0, m_reg[i]});
        chk("rand_op_count", {24'd0, op_count}, m_count);

        // Reset in the WAIT cycle of a LOAD into R6
        host_write(3'd6, 16'h5A5A);
        issue(16'hC000, 1'b0, 3'd0, 16'h0, e);
        while (cyc < e + 1) @(negedge clk);
        do_reset(1);
        @(negedge clk);
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("post_rst_reg6", {16'd0, Reg_6}, 32'd0);
        chk("post_rst_op_count", {24'd0, op_count}, 32'd0);

        // Counter wrap: 256 back-to-back STOREs with start held
        @(negedge clk);
        e0 = cyc + 1;
        for (int k = 0; k < 256; k++) begin
            x.cyc = e0 + 3 * k + 1; x.cnt = 8'(k); x.rx = 3'd2; x.val = 16'h0000; x.ins = 16'h4804;
            done_q.push_back(x);
            run_q.push_back(e0 + 3 * k);
        end
        m_mem[2]  = 16'h0000;
        next_free = e0 + 768;
        start = 1'b1; instruction = 16'h4804;
        mism = 0;
        repeat (766) begin
            @(negedge clk);
            if (ready !== ((cyc - e0) % 3 == 2)) mism++;
            if (cyc == e0 + 765) start = 1'b0;
        end
        chk("wrap_ready_pattern", mism, 0);
        wait_idle();
        chk("wrap_op_count", {24'd0, op_count}, 32'd0);

        repeat (6) @(negedge clk);
        chk("done_q_empty", done_q.size(), 0);
        chk("run_q_empty", run_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
